// File: rtl/uart_port_arbiter.sv
// Shares one UART register port between two byte transmitters and a receive drainer.
// Every bus/handshake output is registered from the next-state decode.
module uart_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic [7:0]  data0_i,
    input  logic [7:0]  data1_i,
    output logic [1:0]  ack_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic        wr_i,
    output logic        reg_sel_i,
    output logic        addr_i,
    output logic [31:0] entrada_i,
    input  logic [31:0] salida_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_READ  = 3'd1,
        RX_CLEAR = 3'd2,
        TX_LOAD  = 3'd3,
        TX_SEND  = 3'd4,
        TX_WAIT  = 3'd5,
        TX_DONE  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [1:0]       ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             rx_valid_q, rx_valid_d;
    logic             wr_q, wr_d;
    logic             reg_sel_q, reg_sel_d;
    logic             addr_q, addr_d;
    logic [31:0]      entrada_q, entrada_d;

    // Only the byte lane and the two control bits of the read port matter here.
    logic salida_unused;
    assign salida_unused = ^salida_o[31:8];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        byte_d    = byte_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rx_data_d = rx_data_q;
        case (state_q)
            IDLE: begin
                if (salida_o[1]) begin
                    state_d = RX_READ;
                end else if (req_i != 2'b00) begin
                    gnt_d   = (req_i == 2'b11) ? ptr_q : req_i[1];
                    byte_d  = gnt_d ? data1_i : data0_i;
                    state_d = TX_LOAD;
                end
            end
            RX_READ: begin
                rx_data_d = salida_o[7:0];
                state_d   = RX_CLEAR;
            end
            RX_CLEAR: state_d = IDLE;
            TX_LOAD:  state_d = TX_SEND;
            TX_SEND: begin
                cnt_d   = '0;
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!salida_o[0]) begin
                    state_d = TX_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = TX_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_DONE: begin
                ptr_d   = ~gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with it once registered.
    always_comb begin
        wr_d       = 1'b0;
        reg_sel_d  = 1'b0;
        addr_d     = 1'b0;
        entrada_d  = 32'h0;
        ack_d      = 2'b00;
        rx_valid_d = 1'b0;
        busy_d     = (state_d != IDLE);
        case (state_d)
            RX_READ: begin
                reg_sel_d = 1'b1;
                addr_d    = 1'b1;
            end
            RX_CLEAR: begin
                wr_d       = 1'b1;
                rx_valid_d = 1'b1;
            end
            TX_LOAD: begin
                wr_d      = 1'b1;
                reg_sel_d = 1'b1;
                entrada_d = {24'h0, byte_d};
            end
            TX_SEND: begin
                wr_d      = 1'b1;
                entrada_d = 32'h1;
            end
            TX_DONE: ack_d = gnt_d ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            gnt_q      <= 1'b0;
            byte_q     <= 8'h0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rx_data_q  <= 8'h0;
            ack_q      <= 2'b00;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            wr_q       <= 1'b0;
            reg_sel_q  <= 1'b0;
            addr_q     <= 1'b0;
            entrada_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            byte_q     <= byte_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rx_data_q  <= rx_data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            wr_q       <= wr_d;
            reg_sel_q  <= reg_sel_d;
            addr_q     <= addr_d;
            entrada_q  <= entrada_d;
        end
    end

    assign ack_o      = ack_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign wr_i       = wr_q;
    assign reg_sel_i  = reg_sel_q;
    assign addr_i     = addr_q;
    assign entrada_i  = entrada_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Bench for uart_port_arbiter: UART register-bank model plus transaction-level expectations.
module tb_uart_port_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [7:0]  data0_i = 8'h0;
    logic [7:0]  data1_i = 8'h0;
    logic [1:0]  ack_o;
    logic        busy_o;
    logic        err_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        wr_i;
    logic        reg_sel_i;
    logic        addr_i;
    logic [31:0] entrada_i;
    logic [31:0] salida_o;

    uart_port_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .data0_i(data0_i), .data1_i(data1_i),
        .ack_o(ack_o), .busy_o(busy_o), .err_o(err_o), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .wr_i(wr_i), .reg_sel_i(reg_sel_i), .addr_i(addr_i),
        .entrada_i(entrada_i), .salida_o(salida_o)
    );

    always #5 clk = ~clk;

    // UART register bank: send clears itself send_delay edges after being set (0 = never).
    logic [1:0] ctrl = 2'b00;
    logic [7:0] tx_reg = 8'h0;
    logic [7:0] rx_reg = 8'h0;
    int         scnt = 0;
    int         send_delay = 2;
    int         inj_req = 0;
    int         inj_done = 0;
    logic [7:0] inj_byte = 8'h0;

    assign salida_o = reg_sel_i ? (addr_i ? {24'h0, rx_reg} : {24'h0, tx_reg}) : {30'h0, ctrl};

    always @(posedge clk) begin
        if (wr_i && reg_sel_i && !addr_i) tx_reg <= entrada_i[7:0];
        if (wr_i && !reg_sel_i) begin
            ctrl <= entrada_i[1:0];
            scnt <= entrada_i[0] ? send_delay : 0;
        end else if (ctrl[0] && scnt != 0) begin
            scnt <= scnt - 1;
            if (scnt == 1) ctrl[0] <= 1'b0;
        end
        if (inj_req != inj_done) begin
            ctrl[1]  <= 1'b1;
            rx_reg   <= inj_byte;
            inj_done <= inj_req;
        end
    end

    int   errors = 0;
    int   checks = 0;
    logic ptr_m = 1'b0;
    logic err_before;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic inject_rx(input logic [7:0] b);
        inj_byte = b;
        inj_req++;
    endtask

    // Waits for the next ack, counting busy cycles on the way; leaves the bench at the ack cycle.
    task automatic wait_ack(input logic [1:0] exp_ack, input logic [7:0] exp_byte,
                            input int exp_busy, input string tag);
        int nb;
        bit got;
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            err_before = err_o;
            @(negedge clk);
            if (busy_o) nb++;
            if (ack_o != 2'b00) got = 1'b1;
        end
        chk(32'(got), 32'd1, {tag, "_seen"});
        chk(32'(ack_o), 32'(exp_ack), {tag, "_ack"});
        chk(32'(tx_reg), 32'(exp_byte), {tag, "_byte"});
        chk(32'(nb), 32'(exp_busy), {tag, "_busy_cycles"});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({21'h0, ack_o, busy_o, err_o, rx_valid_o, wr_i, reg_sel_i, addr_i, 1'b0}, 32'h0, {tag, "_ctl"});
        chk(32'(rx_data_o), 32'h0, {tag, "_rx_data"});
        chk(entrada_i, 32'h0, {tag, "_entrada"});
    endtask

    logic [1:0] reqs;
    logic       rx, first;
    logic [7:0] b0, b1, rb;
    int         d;
    logic [1:0] acc;

    initial begin
        // Reset held two cycles with both requests pending
        req_i = 2'b11; data0_i = 8'h11; data1_i = 8'h22; send_delay = 2;
        @(negedge clk); chk_all_zero("reset_c1");
        @(negedge clk); chk_all_zero("reset_c2");
        rst = 1'b1;

        // Continuous dual request: grants alternate starting from requester 0
        wait_ack(2'b01, 8'h11, 6, "rr0"); ptr_m = 1'b1;
        wait_ack(2'b10, 8'h22, 6, "rr1"); ptr_m = 1'b0;
        wait_ack(2'b01, 8'h11, 6, "rr2"); ptr_m = 1'b1;
        wait_ack(2'b10, 8'h22, 6, "rr3"); ptr_m = 1'b0;
        req_i = 2'b00;

        // Single transfer with bus-level checks; data changes after grant are ignored
        @(negedge clk); chk({30'h0, ack_o, busy_o}, 32'h0, "rr_idle_gap");
        data0_i = 8'hA5; send_delay = 4; req_i = 2'b01;
        @(negedge clk);
        chk({29'h0, wr_i, reg_sel_i, addr_i}, 32'h6, "load_bus");
        chk(entrada_i, 32'h0000_00A5, "load_data");
        data0_i = 8'hFF;
        @(negedge clk);
        chk({29'h0, wr_i, reg_sel_i, addr_i}, 32'h4, "send_bus");
        chk(entrada_i, 32'h1, "send_data");
        req_i = 2'b00;
        wait_ack(2'b01, 8'hA5, 6, "single");
        ptr_m = 1'b1;

        // Receive takes priority over a request seen in the same IDLE cycle
        @(negedge clk); chk({30'h0, ack_o, busy_o}, 32'h0, "ack_pulse");
        data1_i = 8'h77; send_delay = 3;
        inject_rx(8'h3C);
        @(negedge clk);
        req_i = 2'b10;
        @(negedge clk);
        chk({28'h0, wr_i, reg_sel_i, addr_i, rx_valid_o}, 32'h6, "rx_read_bus");
        @(negedge clk);
        chk({28'h0, wr_i, reg_sel_i, addr_i, rx_valid_o}, 32'h9, "rx_clear_bus");
        chk(entrada_i, 32'h0, "rx_clear_data");
        chk(32'(rx_data_o), 32'h3C, "rx_data");
        @(negedge clk);
        chk({30'h0, rx_valid_o, busy_o}, 32'h0, "rx_back_idle");
        chk(32'(rx_data_o), 32'h3C, "rx_data_hold");
        wait_ack(2'b10, 8'h77, 7, "after_rx");
        req_i = 2'b00; ptr_m = 1'b0;

        // Stuck send: abort after the timeout, err sticky afterwards
        data0_i = 8'h5A; send_delay = 0; req_i = 2'b01;
        wait_ack(2'b01, 8'h5A, T + 3, "timeout");
        chk(32'(err_before), 32'h0, "err_before_abort");
        chk(32'(err_o), 32'h1, "err_at_abort");
        req_i = 2'b00; ptr_m = 1'b1;
        @(negedge clk);
        data1_i = 8'hC3; send_delay = 3; req_i = 2'b10;
        wait_ack(2'b10, 8'hC3, 7, "post_timeout");
        chk(32'(err_o), 32'h1, "err_sticky");
        req_i = 2'b00; ptr_m = 1'b0;

        // Randomized traffic against the transaction model
        for (int it = 0; it < 24; it++) begin
            reqs = 2'($urandom_range(1, 3));
            rx   = ($urandom_range(0, 2) == 0);
            b0   = 8'($urandom);
            b1   = 8'($urandom);
            rb   = 8'($urandom);
            d    = $urandom_range(1, 6);
            @(negedge clk); chk({30'h0, ack_o, busy_o}, 32'h0, "rnd_idle_gap");
            data0_i = b0; data1_i = b1; send_delay = d;
            if (rx) begin
                inject_rx(rb);
                @(negedge clk);
            end
            req_i = reqs;
            if (rx) begin
                @(negedge clk);
                chk({28'h0, wr_i, reg_sel_i, addr_i, rx_valid_o}, 32'h6, "rnd_rx_read");
                @(negedge clk);
                chk({28'h0, wr_i, reg_sel_i, addr_i, rx_valid_o}, 32'h9, "rnd_rx_clear");
                chk(32'(rx_data_o), 32'(rb), "rnd_rx_data");
            end
            first = (reqs == 2'b11) ? ptr_m : reqs[1];
            wait_ack(first ? 2'b10 : 2'b01, first ? b1 : b0, d + 4, "rnd_a");
            req_i[first] = 1'b0;
            ptr_m = !first;
            if (reqs == 2'b11) begin
                wait_ack(first ? 2'b01 : 2'b10, first ? b0 : b1, d + 4, "rnd_b");
                req_i[!first] = 1'b0;
                ptr_m = first;
            end
        end
        chk(32'(err_o), 32'h1, "err_sticky_rnd");

        // Reset in TX_WAIT abandons the transfer with no ack
        @(negedge clk);
        data0_i = 8'h99; send_delay = 0; req_i = 2'b01;
        @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
        chk(32'(busy_o), 32'h1, "in_wait_busy");
        rst = 1'b0; req_i = 2'b00;
        @(negedge clk); chk_all_zero("mid_reset");
        rst = 1'b1;
        acc = 2'b00;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            acc = acc | ack_o;
        end
        chk(32'(acc), 32'h0, "no_ack_after_reset");
        ptr_m = 1'b0;

        // Pointer is back at requester 0 after reset
        data0_i = 8'h01; data1_i = 8'h02; send_delay = 2; req_i = 2'b11;
        wait_ack(2'b01, 8'h01, 6, "post_reset_rr0");
        req_i[0] = 1'b0;
        wait_ack(2'b10, 8'h02, 6, "post_reset_rr1");
        req_i = 2'b00;
        @(negedge clk); chk({30'h0, ack_o, busy_o}, 32'h0, "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
